// File: rtl/imem_arbiter_pkg.sv
// imem_arbiter_pkg: arbiter state encoding and default instruction-memory base address.
package imem_arbiter_pkg;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    localparam logic [31:0] IMEM_BASE_ADDR = 32'h0000_3000;

endpackage

// File: rtl/imem_addr_xlate.sv
// imem_addr_xlate: byte address to IM word index, flagging misaligned or out-of-window addresses.
module imem_addr_xlate import imem_arbiter_pkg::*; #(
    parameter logic [31:0] BASE_ADDR = IMEM_BASE_ADDR,
    parameter int          DEPTH     = 4096,
    parameter int          AW        = 12
) (
    input  logic [31:0]   i_addr,
    output logic [AW-1:0] o_idx,
    output logic          o_bad
);

    logic [32:0] w_limit;

    // 33-bit limit so a window ending at the top of the address space cannot wrap
    assign w_limit = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
    assign o_idx   = AW'((i_addr - BASE_ADDR) >> 2);
    assign o_bad   = (i_addr[1:0] != 2'b00) | (i_addr < BASE_ADDR) | ({1'b0, i_addr} >= w_limit);

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares single-port IM between fetch (read) and loader (write) with boot sequencing.
// Optional IMEM_ARB_STATS_EN adds served-fetch, loader-grant and stalled-fetch counters.
module imem_arbiter import imem_arbiter_pkg::*; #(
    parameter logic [31:0] BASE_ADDR = IMEM_BASE_ADDR,
    parameter int          DEPTH     = 4096,
    parameter int          AW        = $clog2(DEPTH),
    parameter int          MAX_WAIT  = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          f_req,
    input  logic [31:0]   f_addr,
    output logic          f_stall,
    output logic          f_err,
    input  logic          l_req,
    input  logic [31:0]   l_addr,
    input  logic [31:0]   l_wdata,
    input  logic          l_done,
    output logic          l_ack,
    output logic          l_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata
`ifdef IMEM_ARB_STATS_EN
    ,
    output logic [31:0]   stat_fetch,
    output logic [31:0]   stat_load,
    output logic [31:0]   stat_stall
`endif
);

    localparam int SW = $clog2(MAX_WAIT + 1);

    arb_state_e    r_state, w_state_nxt;
    logic          r_ack, r_err;
    logic [SW-1:0] r_starve;
    logic          w_lwin, w_l_bad, w_starving;
    logic [AW-1:0] w_l_idx, w_f_idx;

    imem_addr_xlate #(.BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH), .AW(AW)) u_xlate_f (
        .i_addr (f_addr),
        .o_idx  (w_f_idx),
        .o_bad  (f_err)
    );

    imem_addr_xlate #(.BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH), .AW(AW)) u_xlate_l (
        .i_addr (l_addr),
        .o_idx  (w_l_idx),
        .o_bad  (w_l_bad)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_BOOT;
        else          r_state <= w_state_nxt;
    end

    // r_ack blocks a re-grant in the ack cycle, limiting the loader to one write per two cycles
    always_comb begin
        w_starving  = (r_starve == SW'(MAX_WAIT));
        w_lwin      = l_req & ~r_ack & ((r_state == ST_BOOT) | ~f_req | w_starving);
        w_state_nxt = (r_state == ST_BOOT && l_done) ? ST_RUN : r_state;
        mem_addr    = w_lwin ? w_l_idx : w_f_idx;
        mem_we      = w_lwin & ~w_l_bad;
        f_stall     = (r_state == ST_BOOT) | (w_lwin & f_req);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_starve <= '0;
        end else begin
            r_ack    <= w_lwin;
            r_err    <= w_lwin & w_l_bad;
            r_starve <= w_lwin ? '0 :
                        (r_state == ST_RUN && l_req && !r_ack && f_req && !w_starving) ? r_starve + SW'(1) :
                        r_starve;
        end
    end

    assign l_ack     = r_ack;
    assign l_err     = r_err;
    assign mem_wdata = l_wdata;

`ifdef IMEM_ARB_STATS_EN
    logic [31:0] r_fetch, r_load, r_stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch <= '0;
            r_load  <= '0;
            r_stall <= '0;
        end else begin
            if (f_req && !f_stall) r_fetch <= r_fetch + 32'd1;
            if (w_lwin)            r_load  <= r_load + 32'd1;
            if (f_req && f_stall)  r_stall <= r_stall + 32'd1;
        end
    end

    assign stat_fetch = r_fetch;
    assign stat_load  = r_load;
    assign stat_stall = r_stall;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed scenarios plus randomized traffic checked against a cycle-level reference model.
module tb_imem_arbiter;

    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam longint      DEPTH = 4096;
    localparam int          MAXW  = 8;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        f_req = 1'b0, l_req = 1'b0, l_done = 1'b0;
    logic [31:0] f_addr = BASE, l_addr = BASE, l_wdata = 32'h0;
    logic        f_stall, f_err, l_ack, l_err, mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
`ifdef IMEM_ARB_STATS_EN
    logic [31:0] stat_fetch, stat_load, stat_stall;
`endif

    int n_tests = 0, n_fail = 0;

    // reference model: boot/run mode, pending ack, and how many RUN cycles the loader has been refused
    bit          m_run, m_ack, m_err;
    int          m_wait;
    int unsigned m_fetch, m_load, m_stallc;
    bit          e_lwin, e_stall, e_we;
    logic [11:0] e_addr;

    imem_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_stall   (f_stall),
        .f_err     (f_err),
        .l_req     (l_req),
        .l_addr    (l_addr),
        .l_wdata   (l_wdata),
        .l_done    (l_done),
        .l_ack     (l_ack),
        .l_err     (l_err),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata)
`ifdef IMEM_ARB_STATS_EN
        ,
        .stat_fetch(stat_fetch),
        .stat_load (stat_load),
        .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit is_bad(input logic [31:0] a);
        longint x = longint'(a);
        return (x % 4 != 0) || (x < longint'(BASE)) || (x >= longint'(BASE) + 4 * DEPTH);
    endfunction

    function automatic logic [11:0] to_idx(input logic [31:0] a);
        logic [31:0] d = a - BASE;
        return d[13:2];
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return BASE - 32'd4 * $urandom_range(1, 8);
            1:       return BASE + 32'h4000 + 32'd4 * $urandom_range(0, 8);
            2:       return BASE + 32'd4 * $urandom_range(0, 4095) + $urandom_range(1, 3);
            3:       return 32'hFFFF_FFFC;
            default: return BASE + 32'd4 * $urandom_range(0, 4095);
        endcase
    endfunction

    task automatic model_reset();
        m_run = 0; m_ack = 0; m_err = 0; m_wait = 0;
        m_fetch = 0; m_load = 0; m_stallc = 0;
    endtask

    task automatic model_eval();
        e_lwin  = l_req && !m_ack && (!m_run || !f_req || m_wait >= MAXW);
        e_we    = e_lwin && !is_bad(l_addr);
        e_stall = !m_run || (e_lwin && f_req);
        e_addr  = e_lwin ? to_idx(l_addr) : to_idx(f_addr);
    endtask

    task automatic model_tick();
        if (f_req && !e_stall) m_fetch++;
        if (e_lwin)            m_load++;
        if (f_req && e_stall)  m_stallc++;
        if (e_lwin) m_wait = 0;
        else if (m_run && l_req && !m_ack && f_req && m_wait < MAXW) m_wait++;
        m_err = e_lwin && is_bad(l_addr);
        m_ack = e_lwin;
        if (l_done) m_run = 1;
    endtask

    task automatic settle();
        #2;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_reset();
        else          model_tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 0; f_req = 1; f_addr = BASE + 32'h8; l_req = 0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            if (i == 3) reset_n = 1;
            settle();
            n_tests++; if (f_stall !== 1'b1) begin n_fail++; $display("FAIL reset_f_stall cyc=%0d got=%0b exp=1", i, f_stall); end
            n_tests++; if (mem_we !== 1'b0)  begin n_fail++; $display("FAIL reset_mem_we cyc=%0d got=%0b exp=0", i, mem_we); end
            n_tests++; if (l_ack !== 1'b0)   begin n_fail++; $display("FAIL reset_l_ack cyc=%0d got=%0b exp=0", i, l_ack); end
            n_tests++; if (l_err !== 1'b0)   begin n_fail++; $display("FAIL reset_l_err cyc=%0d got=%0b exp=0", i, l_err); end
            tick();
        end
        f_req = 0;
    endtask

    task automatic test_boot_write();
        l_req = 1; l_addr = 32'h3004; l_wdata = 32'hDEADBEEF;
        settle();
        n_tests++; if (mem_we !== 1'b1)            begin n_fail++; $display("FAIL boot_wr_we got=%0b exp=1", mem_we); end
        n_tests++; if (mem_addr !== 12'd1)         begin n_fail++; $display("FAIL boot_wr_addr got=%0h exp=1", mem_addr); end
        n_tests++; if (mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL boot_wr_data got=%0h exp=deadbeef", mem_wdata); end
        tick();
        l_req = 0;
        settle();
        n_tests++; if (l_ack !== 1'b1) begin n_fail++; $display("FAIL boot_wr_ack got=%0b exp=1", l_ack); end
        n_tests++; if (l_err !== 1'b0) begin n_fail++; $display("FAIL boot_wr_err got=%0b exp=0", l_err); end
        tick();
    endtask

    task automatic test_bad_addr();
        logic [31:0] bad_list [3] = '{32'h2FFC, 32'h3002, 32'h7000};
        foreach (bad_list[k]) begin
            l_req = 1; l_addr = bad_list[k];
            settle();
            n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL bad_addr_we addr=%0h got=%0b exp=0", l_addr, mem_we); end
            tick();
            l_req = 0;
            settle();
            n_tests++; if (l_ack !== 1'b1) begin n_fail++; $display("FAIL bad_addr_ack addr=%0h got=%0b exp=1", l_addr, l_ack); end
            n_tests++; if (l_err !== 1'b1) begin n_fail++; $display("FAIL bad_addr_err addr=%0h got=%0b exp=1", l_addr, l_err); end
            tick();
        end
    endtask

    task automatic test_run_fetch();
        l_done = 1;
        settle();
        tick();
        l_done = 0; f_req = 1; f_addr = 32'h3008;
        settle();
        n_tests++; if (f_stall !== 1'b0)    begin n_fail++; $display("FAIL run_fetch_stall got=%0b exp=0", f_stall); end
        n_tests++; if (mem_addr !== 12'd2)  begin n_fail++; $display("FAIL run_fetch_addr got=%0h exp=2", mem_addr); end
        n_tests++; if (f_err !== 1'b0)      begin n_fail++; $display("FAIL run_fetch_err got=%0b exp=0", f_err); end
        f_addr = 32'h3006;
        #1;
        model_eval();
        n_tests++; if (f_err !== 1'b1)      begin n_fail++; $display("FAIL run_fetch_misalign got=%0b exp=1", f_err); end
        tick();
    endtask

    task automatic test_starve();
        f_req = 1; f_addr = 32'h3010; l_req = 1; l_addr = 32'h3020; l_wdata = $urandom;
        for (int i = 0; i < MAXW; i++) begin
            settle();
            n_tests++; if (mem_we !== 1'b0 || f_stall !== 1'b0) begin
                n_fail++; $display("FAIL starve_deny cyc=%0d we=%0b stall=%0b exp we=0 stall=0", i, mem_we, f_stall);
            end
            tick();
        end
        settle();
        n_tests++; if (mem_we !== 1'b1)     begin n_fail++; $display("FAIL starve_grant_we got=%0b exp=1", mem_we); end
        n_tests++; if (f_stall !== 1'b1)    begin n_fail++; $display("FAIL starve_grant_stall got=%0b exp=1", f_stall); end
        n_tests++; if (mem_addr !== 12'd8)  begin n_fail++; $display("FAIL starve_grant_addr got=%0h exp=8", mem_addr); end
        tick();
        l_req = 0;
        settle();
        n_tests++; if (l_ack !== 1'b1)      begin n_fail++; $display("FAIL starve_ack got=%0b exp=1", l_ack); end
        n_tests++; if (f_stall !== 1'b0)    begin n_fail++; $display("FAIL starve_fetch_stall got=%0b exp=0", f_stall); end
        n_tests++; if (mem_addr !== 12'd4)  begin n_fail++; $display("FAIL starve_fetch_addr got=%0h exp=4", mem_addr); end
        tick();
        f_req = 0;
    endtask

    task automatic test_reset_mid_write();
        l_req = 1; l_addr = 32'h3040;
        settle();
        n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL midrst_grant got=%0b exp=1", mem_we); end
        reset_n = 0; l_req = 0;
        model_reset();
        #1;
        model_eval();
        n_tests++; if (f_stall !== 1'b1 || mem_we !== 1'b0 || l_ack !== 1'b0) begin
            n_fail++; $display("FAIL midrst_async stall=%0b we=%0b ack=%0b exp 1/0/0", f_stall, mem_we, l_ack);
        end
        tick();
        n_tests++; if (l_ack !== 1'b0 || l_err !== 1'b0) begin
            n_fail++; $display("FAIL midrst_no_ack ack=%0b err=%0b exp 0/0", l_ack, l_err);
        end
`ifdef IMEM_ARB_STATS_EN
        n_tests++; if (stat_fetch !== 0 || stat_load !== 0 || stat_stall !== 0) begin
            n_fail++; $display("FAIL midrst_stats fetch=%0d load=%0d stall=%0d exp 0", stat_fetch, stat_load, stat_stall);
        end
`endif
        reset_n = 1; f_req = 1; f_addr = BASE;
        settle();
        n_tests++; if (f_stall !== 1'b1) begin n_fail++; $display("FAIL midrst_boot_stall got=%0b exp=1", f_stall); end
        tick();
        f_req = 0;
    endtask

    task automatic test_random();
        reset_n = 0; f_req = 0; l_req = 0; l_done = 0;
        model_reset();
        tick();
        reset_n = 1;
        for (int c = 0; c < 400; c++) begin
            l_done = (c == 40) || ($urandom_range(0, 99) == 0);
            f_req  = $urandom_range(0, 3) != 0;
            f_addr = rand_addr();
            if (l_req && l_ack) begin
                l_req = $urandom_range(0, 1);
                l_addr = rand_addr(); l_wdata = $urandom;
            end else if (!l_req && $urandom_range(0, 2) == 0) begin
                l_req = 1; l_addr = rand_addr(); l_wdata = $urandom;
            end
            settle();
            n_tests++; if (f_stall !== e_stall)  begin n_fail++; $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", c, f_stall, e_stall); end
            n_tests++; if (f_err !== is_bad(f_addr)) begin n_fail++; $display("FAIL rnd_f_err cyc=%0d addr=%0h got=%0b", c, f_addr, f_err); end
            n_tests++; if (mem_we !== e_we)      begin n_fail++; $display("FAIL rnd_we cyc=%0d got=%0b exp=%0b", c, mem_we, e_we); end
            n_tests++; if (mem_addr !== e_addr)  begin n_fail++; $display("FAIL rnd_addr cyc=%0d got=%0h exp=%0h", c, mem_addr, e_addr); end
            n_tests++; if (mem_wdata !== l_wdata) begin n_fail++; $display("FAIL rnd_wdata cyc=%0d got=%0h exp=%0h", c, mem_wdata, l_wdata); end
            n_tests++; if (l_ack !== m_ack || l_err !== m_err) begin
                n_fail++; $display("FAIL rnd_ack cyc=%0d ack=%0b err=%0b exp %0b/%0b", c, l_ack, l_err, m_ack, m_err);
            end
            tick();
        end
`ifdef IMEM_ARB_STATS_EN
        n_tests++; if (stat_fetch !== m_fetch) begin n_fail++; $display("FAIL rnd_stat_fetch got=%0d exp=%0d", stat_fetch, m_fetch); end
        n_tests++; if (stat_load !== m_load)   begin n_fail++; $display("FAIL rnd_stat_load got=%0d exp=%0d", stat_load, m_load); end
        n_tests++; if (stat_stall !== m_stallc) begin n_fail++; $display("FAIL rnd_stat_stall got=%0d exp=%0d", stat_stall, m_stallc); end
`endif
    endtask

    initial begin
        test_reset();
        test_boot_write();
        test_bad_addr();
        test_run_fetch();
        test_starve();
        test_reset_mid_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
